// File: rtl/pc_gen_pkg.sv
// Shared types and helpers for the IF-stage fetch-address generator.
// The state encoding, default bubble address and address alignment live here.
package pc_gen_pkg;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        SHADOW = 2'd2
    } pc_state_e;

    localparam logic [31:0] DEFAULT_BUBBLE_PC = 32'hFFFF_FF00;

    // Widest address the alignment helper handles; callers cast down to XLEN.
    localparam int MAX_XLEN = 64;

    function automatic logic [MAX_XLEN-1:0] align_addr(
        input logic [MAX_XLEN-1:0] addr,
        input int unsigned         inst_bytes
    );
        logic [MAX_XLEN-1:0] mask;
        mask = ~(MAX_XLEN'(inst_bytes) - MAX_XLEN'(1));
        return addr & mask;
    endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Fetch-address bus between the PC generator (master) and the fetch stage.
// Carries hazard controls and redirects in, and the fetch address handshake out.
interface pc_gen_if #(
    parameter int XLEN = 32
);

    logic            stall_i;
    logic            branch_stop_i;
    logic            redirect_i;
    logic [XLEN-1:0] redirect_pc_i;
    logic            fetch_ready_i;
    logic [XLEN-1:0] pc_o;
    logic            pc_valid_o;
    logic [XLEN-1:0] pc_seq_o;

    modport master (
        input  stall_i,
        input  branch_stop_i,
        input  redirect_i,
        input  redirect_pc_i,
        input  fetch_ready_i,
        output pc_o,
        output pc_valid_o,
        output pc_seq_o
    );

    modport slave (
        output stall_i,
        output branch_stop_i,
        output redirect_i,
        output redirect_pc_i,
        output fetch_ready_i,
        input  pc_o,
        input  pc_valid_o,
        input  pc_seq_o
    );

endinterface

// File: rtl/pc_bubble_cnt.sv
// Loadable 3-bit down-counter tracking the remaining bubble slots of a branch shadow.
// Clear beats load, load beats decrement; the count never wraps below zero.
module pc_bubble_cnt (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear_i,
    input  logic       load_i,
    input  logic [2:0] load_val_i,
    input  logic       en_i,
    output logic       zero_o
);

    logic [2:0] cnt_q;
    logic [2:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = 3'd0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != 3'd0)) begin
            cnt_d = cnt_q - 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 3'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == 3'd0);

endmodule

// File: rtl/pc_gen.sv
// Fetch-address generator: boots to RESET_VEC, advances sequentially, honours
// redirects and load-use stalls, and emits bubble slots during branch shadows.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int              XLEN           = 32,
    parameter logic [XLEN-1:0] RESET_VEC      = '0,
    parameter logic [XLEN-1:0] BUBBLE_PC      = XLEN'(DEFAULT_BUBBLE_PC),
    parameter int unsigned     INST_BYTES     = 4,
    parameter int unsigned     BRANCH_BUBBLES = 1
) (
    input  logic     clk,
    input  logic     rst,
    pc_gen_if.master bus
);

    localparam logic [XLEN-1:0] PC_INC      = XLEN'(INST_BYTES);
    localparam logic [2:0]      SHADOW_LOAD = 3'(BRANCH_BUBBLES - 1);

    pc_state_e       state_q;
    pc_state_e       state_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] saved_q;
    logic [XLEN-1:0] saved_d;

    logic            cnt_clear;
    logic            cnt_load;
    logic            cnt_dec;
    logic            cnt_zero;

    logic [XLEN-1:0] redirect_aligned;
    logic [XLEN-1:0] pc_out;
    logic            pc_valid_out;

    assign redirect_aligned = XLEN'(align_addr(MAX_XLEN'(bus.redirect_pc_i), INST_BYTES));

    pc_bubble_cnt u_bubble_cnt (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (cnt_clear),
        .load_i     (cnt_load),
        .load_val_i (SHADOW_LOAD),
        .en_i       (cnt_dec),
        .zero_o     (cnt_zero)
    );

    // Priority inside RUN/SHADOW: redirect, stall, branch_stop, then advance.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        saved_d   = saved_q;
        cnt_clear = 1'b0;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;

        unique case (state_q)
            RUN, SHADOW: begin
                if (bus.redirect_i) begin
                    pc_d      = redirect_aligned;
                    state_d   = RUN;
                    cnt_clear = 1'b1;
                end else if (!bus.stall_i) begin
                    if (state_q == RUN) begin
                        if (bus.branch_stop_i) begin
                            saved_d  = pc_q;
                            state_d  = SHADOW;
                            cnt_load = 1'b1;
                        end else if (bus.fetch_ready_i) begin
                            pc_d = pc_q + PC_INC;
                        end
                    end else if (!cnt_zero) begin
                        cnt_dec = 1'b1;
                    end else begin
                        state_d = RUN;
                        pc_d    = saved_q + PC_INC;
                    end
                end
            end
            default: begin
                state_d = RUN;
                pc_d    = RESET_VEC;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_VEC;
            saved_q <= RESET_VEC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            saved_q <= saved_d;
        end
    end

    always_comb begin
        pc_out       = RESET_VEC;
        pc_valid_out = 1'b0;
        unique case (state_q)
            RUN: begin
                pc_out       = pc_q;
                pc_valid_out = 1'b1;
            end
            SHADOW: begin
                pc_out = BUBBLE_PC;
            end
            default: begin
                pc_out       = RESET_VEC;
                pc_valid_out = 1'b0;
            end
        endcase
    end

    assign bus.pc_o       = pc_out;
    assign bus.pc_valid_o = pc_valid_out;
    assign bus.pc_seq_o   = pc_out + PC_INC;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: one instance with the default single-bubble
// shadow and one with a three-bubble shadow, checked through an expectation queue.
module tb_pc_gen;

    typedef struct packed {
        logic        stall;
        logic        bstop;
        logic        redir;
        logic [31:0] rpc;
        logic        ready;
        logic [31:0] pc;
        logic        valid;
    } stim_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        valid;
    } exp_t;

    localparam logic [31:0] BUBBLE = 32'hFFFF_FF00;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    pc_gen_if #(.XLEN(32)) bus1 ();
    pc_gen_if #(.XLEN(32)) bus3 ();

    pc_gen #(.XLEN(32), .BRANCH_BUBBLES(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.master)
    );

    pc_gen #(.XLEN(32), .BRANCH_BUBBLES(3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3.master)
    );

    // Applies one cycle of stimulus, records what the outputs must show after the edge.
    task automatic drive_cycle(input bit sel3, input stim_t s);
        exp_t e;
        if (sel3) begin
            bus3.stall_i       = s.stall;
            bus3.branch_stop_i = s.bstop;
            bus3.redirect_i    = s.redir;
            bus3.redirect_pc_i = s.rpc;
            bus3.fetch_ready_i = s.ready;
        end else begin
            bus1.stall_i       = s.stall;
            bus1.branch_stop_i = s.bstop;
            bus1.redirect_i    = s.redir;
            bus1.redirect_pc_i = s.rpc;
            bus1.fetch_ready_i = s.ready;
        end
        e.pc    = s.pc;
        e.valid = s.valid;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        stim_t rows [3];
        exp_t  e;
        logic [31:0] seq;
        rows = '{
            '{1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1},
            '{1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h4, 1'b1},
            '{1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h8, 1'b1}
        };
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus1.pc_o !== 32'h0 || bus1.pc_valid_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_hold: pc_o=%h valid=%b, expected pc_o=00000000 valid=0",
                     bus1.pc_o, bus1.pc_valid_o);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus1.pc_o !== 32'h0 || bus1.pc_valid_o !== 1'b0 || bus3.pc_valid_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL boot: pc_o=%h valid=%b valid3=%b, expected pc_o=00000000 valid=0",
                     bus1.pc_o, bus1.pc_valid_o, bus3.pc_valid_o);
        end
        foreach (rows[i]) begin
            drive_cycle(1'b0, rows[i]);
            e   = exp_q.pop_front();
            seq = e.pc + 32'd4;
            checks++;
            if (bus1.pc_o !== e.pc || bus1.pc_valid_o !== e.valid || bus1.pc_seq_o !== seq) begin
                errors++;
                $display("[TB] FAIL reset_seq[%0d]: pc_o=%h valid=%b seq=%h, expected %h %b %h",
                         i, bus1.pc_o, bus1.pc_valid_o, bus1.pc_seq_o, e.pc, e.valid, seq);
            end
        end
    endtask

    task automatic test_stall();
        stim_t rows [3];
        exp_t  e;
        logic [31:0] seq;
        rows = '{
            '{1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h8, 1'b1},
            '{1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h8, 1'b1},
            '{1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hC, 1'b1}
        };
        foreach (rows[i]) begin
            drive_cycle(1'b0, rows[i]);
            e   = exp_q.pop_front();
            seq = e.pc + 32'd4;
            checks++;
            if (bus1.pc_o !== e.pc || bus1.pc_valid_o !== e.valid || bus1.pc_seq_o !== seq) begin
                errors++;
                $display("[TB] FAIL stall[%0d]: pc_o=%h valid=%b seq=%h, expected %h %b %h",
                         i, bus1.pc_o, bus1.pc_valid_o, bus1.pc_seq_o, e.pc, e.valid, seq);
            end
        end
    endtask

    // Single-bubble shadow, a branch_stop dropped under stall, and a stalled shadow.
    task automatic test_not_taken();
        stim_t rows [9];
        exp_t  e;
        logic [31:0] seq;
        rows = '{
            '{1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h10, 1'b1},
            '{1'b0, 1'b1, 1'b0, 32'h0, 1'b1, BUBBLE,  1'b0},
            '{1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h14, 1'b1},
            '{1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h18, 1'b1},
            '{1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h18, 1'b1},
            '{1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h1C, 1'b1},
            '{1'b0, 1'b1, 1'b0, 32'h0, 1'b1, BUBBLE,  1'b0},
            '{1'b1, 1'b0, 1'b0, 32'h0, 1'b1, BUBBLE,  1'b0},
            '{1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h20, 1'b1}
        };
        foreach (rows[i]) begin
            drive_cycle(1'b0, rows[i]);
            e   = exp_q.pop_front();
            seq = e.pc + 32'd4;
            checks++;
            if (bus1.pc_o !== e.pc || bus1.pc_valid_o !== e.valid || bus1.pc_seq_o !== seq) begin
                errors++;
                $display("[TB] FAIL not_taken[%0d]: pc_o=%h valid=%b seq=%h, expected %h %b %h",
                         i, bus1.pc_o, bus1.pc_valid_o, bus1.pc_seq_o, e.pc, e.valid, seq);
            end
        end
    endtask

    task automatic test_priority();
        stim_t rows [8];
        exp_t  e;
        logic [31:0] seq;
        rows = '{
            '{1'b1, 1'b1, 1'b1, 32'h40, 1'b1, 32'h40, 1'b1},
            '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h44, 1'b1},
            '{1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h44, 1'b1},
            '{1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h44, 1'b1},
            '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h48, 1'b1},
            '{1'b0, 1'b0, 1'b1, 32'h83, 1'b0, 32'h80, 1'b1},
            '{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, BUBBLE,  1'b0},
            '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h84, 1'b1}
        };
        foreach (rows[i]) begin
            drive_cycle(1'b0, rows[i]);
            e   = exp_q.pop_front();
            seq = e.pc + 32'd4;
            checks++;
            if (bus1.pc_o !== e.pc || bus1.pc_valid_o !== e.valid || bus1.pc_seq_o !== seq) begin
                errors++;
                $display("[TB] FAIL priority[%0d]: pc_o=%h valid=%b seq=%h, expected %h %b %h",
                         i, bus1.pc_o, bus1.pc_valid_o, bus1.pc_seq_o, e.pc, e.valid, seq);
            end
        end
    endtask

    task automatic test_wrap();
        stim_t rows [3];
        exp_t  e;
        logic [31:0] seq;
        rows = '{
            '{1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC, 1'b1},
            '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0,         1'b1},
            '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h4,         1'b1}
        };
        foreach (rows[i]) begin
            drive_cycle(1'b0, rows[i]);
            e   = exp_q.pop_front();
            seq = e.pc + 32'd4;
            checks++;
            if (bus1.pc_o !== e.pc || bus1.pc_valid_o !== e.valid || bus1.pc_seq_o !== seq) begin
                errors++;
                $display("[TB] FAIL wrap[%0d]: pc_o=%h valid=%b seq=%h, expected %h %b %h",
                         i, bus1.pc_o, bus1.pc_valid_o, bus1.pc_seq_o, e.pc, e.valid, seq);
            end
        end
    endtask

    // Three-bubble shadow: redirect in bubble 2, then a full shadow with an ignored
    // branch_stop and a stalled bubble.
    task automatic test_taken_long_shadow();
        stim_t rows [10];
        exp_t  e;
        logic [31:0] seq;
        rows = '{
            '{1'b0, 1'b0, 1'b1, 32'h20,  1'b1, 32'h20,  1'b1},
            '{1'b0, 1'b1, 1'b0, 32'h0,   1'b1, BUBBLE,   1'b0},
            '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, BUBBLE,   1'b0},
            '{1'b0, 1'b0, 1'b1, 32'h103, 1'b1, 32'h100, 1'b1},
            '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h104, 1'b1},
            '{1'b0, 1'b1, 1'b0, 32'h0,   1'b1, BUBBLE,   1'b0},
            '{1'b0, 1'b1, 1'b0, 32'h0,   1'b1, BUBBLE,   1'b0},
            '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, BUBBLE,   1'b0},
            '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, BUBBLE,   1'b0},
            '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h108, 1'b1}
        };
        foreach (rows[i]) begin
            drive_cycle(1'b1, rows[i]);
            e   = exp_q.pop_front();
            seq = e.pc + 32'd4;
            checks++;
            if (bus3.pc_o !== e.pc || bus3.pc_valid_o !== e.valid || bus3.pc_seq_o !== seq) begin
                errors++;
                $display("[TB] FAIL taken3[%0d]: pc_o=%h valid=%b seq=%h, expected %h %b %h",
                         i, bus3.pc_o, bus3.pc_valid_o, bus3.pc_seq_o, e.pc, e.valid, seq);
            end
        end
    endtask

    // Reset asserted between edges while in a stalled shadow must act immediately.
    task automatic test_async_reset();
        stim_t rows [1];
        exp_t  e;
        rows = '{'{1'b0, 1'b1, 1'b0, 32'h0, 1'b1, BUBBLE, 1'b0}};
        drive_cycle(1'b0, rows[0]);
        e = exp_q.pop_front();
        checks++;
        if (bus1.pc_o !== e.pc || bus1.pc_valid_o !== e.valid) begin
            errors++;
            $display("[TB] FAIL pre_reset_shadow: pc_o=%h valid=%b, expected %h %b",
                     bus1.pc_o, bus1.pc_valid_o, e.pc, e.valid);
        end
        bus1.stall_i = 1'b1;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus1.pc_o !== 32'h0 || bus1.pc_valid_o !== 1'b0 || bus1.pc_seq_o !== 32'h4 ||
            bus3.pc_valid_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset: pc_o=%h valid=%b seq=%h valid3=%b, expected 00000000 0 00000004 0",
                     bus1.pc_o, bus1.pc_valid_o, bus1.pc_seq_o, bus3.pc_valid_o);
        end
        @(negedge clk);
        rst          = 1'b0;
        bus1.stall_i = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus1.pc_o !== 32'h0 || bus1.pc_valid_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL post_reset_run: pc_o=%h valid=%b, expected 00000000 1",
                     bus1.pc_o, bus1.pc_valid_o);
        end
    endtask

    initial begin
        bus1.stall_i = 1'b0; bus1.branch_stop_i = 1'b0; bus1.redirect_i = 1'b0;
        bus1.redirect_pc_i = 32'h0; bus1.fetch_ready_i = 1'b1;
        bus3.stall_i = 1'b0; bus3.branch_stop_i = 1'b0; bus3.redirect_i = 1'b0;
        bus3.redirect_pc_i = 32'h0; bus3.fetch_ready_i = 1'b1;

        test_reset();
        test_stall();
        test_not_taken();
        test_priority();
        test_wrap();
        test_taken_long_shadow();
        test_async_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised fetch-address generator for the 5-stage pipeline, sitting in IF ahead of instruction memory. It computes the sequential next PC internally, accepts a resolved-branch redirect, and freezes on load-use hazards. During a control-hazard shadow it emits a configurable number of bubble slots, marked by a valid flag rather than by an address alone. It presents each fetch address on a valid/ready handshake to the fetch stage.

## Interface
- `XLEN`, 32, address width.
- `RESET_VEC`, 0, first fetch address after reset.
- `BUBBLE_PC`, 32'hFFFF_FF00 (sized to XLEN), address driven during bubble slots.
- `INST_BYTES`, 4, sequential increment; power of two.
- `BRANCH_BUBBLES`, 1, bubble slots per branch shadow; legal range 1..7.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `stall_i` in 1: load-use freeze.
- `branch_stop_i` in 1: branch detected in decode; open a shadow.
- `redirect_i` in 1: resolved taken branch or jump.
- `redirect_pc_i` in XLEN: redirect target.
- `fetch_ready_i` in 1: fetch stage accepts `pc_o` this cycle.
- `pc_o` out XLEN: fetch address.
- `pc_valid_o` out 1: `pc_o` is a real fetch; 0 marks a bubble.
- `pc_seq_o` out XLEN: `pc_o + INST_BYTES`, combinational.

## Operation
- Registered state is `state_q` (BOOT, RUN, SHADOW), `pc_q`, `saved_q`, and `cnt_q` (3 bits).
- **Reset:** `state_q=BOOT`, `pc_q=RESET_VEC`, `pc_valid_o=0`, `cnt_q=0`, `saved_q=RESET_VEC`.
- **BOOT:** for exactly one cycle after reset release, move to RUN with `pc_q=RESET_VEC`. All inputs are ignored in BOOT.
- **Per-cycle priority in RUN and SHADOW:** redirect, then stall, then branch_stop, then advance.
  - **redirect_i:** `pc_q = redirect_pc_i` with its low log2(INST_BYTES) bits forced to 0; state becomes RUN; `cnt_q` clears. Redirect overrides `stall_i` and backpressure.
  - **stall_i:** hold `pc_q`, `state_q` and `cnt_q`. A branch_stop arriving in the same cycle is dropped; decode must re-assert it.
  - **branch_stop_i in RUN:** `saved_q = pc_q`; state becomes SHADOW; `cnt_q = BRANCH_BUBBLES-1`.
  - **branch_stop_i in SHADOW:** ignored.
  - **Advance in RUN:** when `fetch_ready_i=1`, `pc_q = pc_q + INST_BYTES`. Otherwise hold.
  - **Advance in SHADOW:** if `cnt_q != 0`, decrement. If `cnt_q == 0`, return to RUN with `pc_q = saved_q + INST_BYTES` (fall-through). `fetch_ready_i` does not gate bubble retirement.
- **Outputs:**
  - In SHADOW: `pc_o = BUBBLE_PC`, `pc_valid_o = 0`.
  - In RUN: `pc_o = pc_q`, `pc_valid_o = 1`.
  - In BOOT: `pc_o = RESET_VEC`, `pc_valid_o = 0`.
- **Arithmetic:** modulo 2^XLEN; all-ones-aligned + INST_BYTES wraps to 0 with no flag.

## Timing
- All state changes occur on the rising edge. Outputs are registered except `pc_seq_o`.
- Reset release to first valid PC takes 1 cycle (BOOT).
- Handshake rule: while `pc_valid_o=1` and `fetch_ready_i=0`, `pc_o` is stable unless `redirect_i` or `branch_stop_i` fires. Those flush the slot.
- Redirect to target: visible on `pc_o` 1 cycle after `redirect_i` is sampled.
- Shadow length is exactly `BRANCH_BUBBLES` non-stalled cycles with `pc_valid_o=0`. Stalled cycles extend the shadow.
- Asserting `rst` mid-shadow or mid-stall returns to BOOT immediately (asynchronously), with all outputs at reset values.

## Structure
- `pc_gen_pkg` holds:
  - state enum `pc_state_e` (BOOT, RUN, SHADOW);
  - the default `BUBBLE_PC` constant;
  - a function aligning an address to INST_BYTES.
- Sub-module `pc_bubble_cnt` is a loadable 3-bit down-counter with load, enable (not stalled), and zero flag.
- The top level holds the FSM, `pc_q`/`saved_q` and the output mux.

## Test plan
- **Reset and boot:** pulse `rst`, hold `fetch_ready_i=1`.
  - Expect 1 cycle of `pc_valid_o=0`, `pc_o=0`.
  - Then 0x0, 0x4, 0x8 on consecutive cycles.
- **Load-use stall:** at `pc_o=0x8`, assert `stall_i` for 2 cycles. Expect `pc_o=0x8` held for 3 cycles, then 0xC.
- **Not-taken branch:** default parameters, `branch_stop_i` at `pc_o=0x10`, no redirect. Expect `pc_o=0xFFFF_FF00`, `valid=0` for 1 cycle, then 0x14.
- **Taken branch with a longer shadow:** with `BRANCH_BUBBLES=3`, `branch_stop_i` at `pc_o=0x20`, then `redirect_i` with `redirect_pc_i=0x103` in bubble cycle 2. Expect 2 bubbles, then `pc_o=0x100` (aligned).
- **Priority and backpressure:**
  - `stall_i`, `branch_stop_i` and `redirect_i` together, target 0x40: expect `pc_o=0x40` next cycle.
  - `fetch_ready_i=0` at 0x44: expect 0x44 held until ready.
- **Wrap:** redirect to 0xFFFF_FFFC. Expect `pc_seq_o=0`, and next `pc_o=0x0`.
